// File: rtl/fifo_rr_arbiter_if.sv
// Producer/consumer/FIFO-pin bundle for fifo_rr_arbiter.
// master = arbiter side, slave = producers, consumer and FIFO side.
interface fifo_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic                     cons_pop;
    logic                     cons_ack;
    logic                     fifo_push;
    logic [WIDTH-1:0]         fifo_data;
    logic                     fifo_pop;
    logic [OCC_W-1:0]         occupancy;
    logic                     arb_full;
    logic                     arb_empty;

    modport master (
        input  req, req_data, cons_pop,
        output gnt, cons_ack, fifo_push, fifo_data, fifo_pop,
        output occupancy, arb_full, arb_empty
    );

    modport slave (
        output req, req_data, cons_pop,
        input  gnt, cons_ack, fifo_push, fifo_data, fifo_pop,
        input  occupancy, arb_full, arb_empty
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin push arbiter with credit-tracked occupancy in front of a FIFO.
// Define ARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of RR.
module fifo_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    fifo_rr_arbiter_if.master bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt_q;
    logic               push_q;
    logic [WIDTH-1:0]   data_q;
    logic               pop_q;
    logic               ack_q;
    logic [OCC_W-1:0]   occ_q;

    logic               pop_ok;
    logic               room;
    logic [NUM_REQ-1:0] elig;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    int                 j;

`ifndef ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
`endif

    assign pop_ok = bus.cons_pop && (occ_q != '0);
    // A pop at the same edge frees the slot a push would need when full.
    assign room   = (occ_q < OCC_W'(DEPTH)) || pop_ok;
    assign elig   = bus.req & ~gnt_q & {NUM_REQ{room}};

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            j = i;
`else
            j = (int'(rr_ptr) + i) % NUM_REQ;
`endif
            if (!win_found && elig[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    assign rr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q  <= '0;
            push_q <= 1'b0;
            data_q <= '0;
            pop_q  <= 1'b0;
            ack_q  <= 1'b0;
            occ_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`endif
        end else begin
            gnt_q  <= win_found ? (NUM_REQ'(1) << win_idx) : '0;
            push_q <= win_found;
            pop_q  <= pop_ok;
            ack_q  <= pop_ok;
            if (win_found) begin
                data_q <= bus.req_data[win_idx*WIDTH +: WIDTH];
`ifndef ARB_FIXED_PRIO_EN
                rr_ptr <= rr_next;
`endif
            end
            if (win_found && !pop_ok)
                occ_q <= occ_q + 1'b1;
            else if (!win_found && pop_ok)
                occ_q <= occ_q - 1'b1;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.fifo_push = push_q;
    assign bus.fifo_data = data_q;
    assign bus.fifo_pop  = pop_q;
    assign bus.cons_ack  = ack_q;
    assign bus.occupancy = occ_q;
    assign bus.arb_full  = (occ_q == OCC_W'(DEPTH));
    assign bus.arb_empty = (occ_q == '0);
endmodule
